// File: rtl/fifo_uart_tx.sv
// Purpose : pops one word from the upstream fifo and sends it as a UART frame
//           (start, WIDTH data bits LSB first, optional parity, one stop bit).
// Latency : tx_o falls 3 cycles after IDLE sees a non-empty fifo; a frame lasts
//           (WIDTH+2+PARITY_EN)*CLKS_PER_BIT cycles, and done_o pulses in the cycle after it.
// Backpress: pulls data only when enable_i=1 and empty_i=0; one pop per frame,
//           with no further pop until the current frame has finished.
//
// Ports:
//   clk_i    rising-edge clock shared with the fifo
//   rst_ni   asynchronous active-low reset
//   enable_i permission to start new frames; a frame in flight always completes
//   empty_i  fifo empty flag, looked at only in IDLE
//   rd_en_o  single-cycle fifo pop request
//   rdata_i  fifo read data, captured in LOAD (the cycle after the pop)
//   tx_o     serial output, idles high
//   busy_o   high in every state except IDLE
//   done_o   one-cycle pulse on return to IDLE after the stop bit
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             empty_i,
    output logic             rd_en_o,
    input  logic [WIDTH-1:0] rdata_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               rd_en_q, rd_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        par_d   = par_q;

        // Every serial-bit state shares the same baud count: wrap on the bit boundary.
        if (state_q == S_START || state_q == S_DATA ||
            state_q == S_PARITY || state_q == S_STOP) begin
            if (bit_end) begin
                baud_d = '0;
            end else begin
                baud_d = baud_q + BAUD_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (enable_i && !empty_i) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = rdata_i;
                par_d   = (^rdata_i) ^ PARITY_ODD;
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next-state values and then registered, so each
    // output lines up with the state it belongs to and never sees an input directly.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        rd_en_d = (state_d == S_FETCH);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_o    = tx_q;
    assign rd_en_o = rd_en_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: one main instance (no parity) fed by a fifo model and a
// frame monitor with a scoreboard, plus odd- and even-parity instances for the parity frame.
module tb_fifo_uart_tx;

    localparam int W   = 8;
    localparam int CPB = 4;
    localparam int F0  = (W + 2) * CPB;
    localparam int FP  = (W + 3) * CPB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // main lane
    logic         en0 = 1'b1;
    logic         empty0, rd_en0, tx0, busy0, done0;
    logic [W-1:0] rdata0 = '0;

    // parity lanes
    logic         en_p = 1'b1;
    logic         empty_po, rd_po, tx_po, busy_po, done_po;
    logic         empty_pe, rd_pe, tx_pe, busy_pe, done_pe;
    logic [W-1:0] rdata_po = '0, rdata_pe = '0;

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en0), .empty_i(empty0), .rd_en_o(rd_en0),
        .rdata_i(rdata0), .tx_o(tx0), .busy_o(busy0), .done_o(done0));

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_po (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en_p), .empty_i(empty_po), .rd_en_o(rd_po),
        .rdata_i(rdata_po), .tx_o(tx_po), .busy_o(busy_po), .done_o(done_po));

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_pe (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en_p), .empty_i(empty_pe), .rd_en_o(rd_pe),
        .rdata_i(rdata_pe), .tx_o(tx_pe), .busy_o(busy_pe), .done_o(done_pe));

    // fifo model for the main lane: rdata valid the cycle after a pop
    logic [W-1:0] mem [256];
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    logic ferr = 1'b0;
    assign empty0 = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (rd_en0) begin
            if (wr_cnt == rd_cnt) begin
                ferr <= 1'b1;
            end else begin
                rdata0 <= mem[rd_cnt[7:0]];
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    // one-word source shared by the parity lanes, each with its own read count
    logic [W-1:0] pw = '0;
    int pw_wr = 0;
    int po_rd = 0;
    int pe_rd = 0;
    assign empty_po = (pw_wr == po_rd);
    assign empty_pe = (pw_wr == pe_rd);

    always @(posedge clk) begin
        if (rd_po) begin
            rdata_po <= pw;
            po_rd    <= po_rd + 1;
        end
        if (rd_pe) begin
            rdata_pe <= pw;
            pe_rd    <= pe_rd + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Per-cycle tx waveform of a frame: bit k of the result is tx in cycle k after the start edge.
    function automatic logic [63:0] exp_wave(input logic [W-1:0] d, input bit pen, input bit par);
        logic [11:0] bits;
        int          nb;
        logic [63:0] w;
        bits    = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < W; i++) bits[i+1] = d[i];
        nb = W + 1;
        if (pen) begin
            bits[nb] = par;
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        w = '0;
        for (int b = 0; b < nb; b++)
            for (int c = 0; c < CPB; c++) w[b*CPB+c] = bits[b];
        return w;
    endfunction

    logic [W-1:0] sb[$];
    int           mon_starts[$];
    int           rd_pulses = 0;
    int           done_pulses = 0;

    always @(negedge clk) begin
        if (rd_en0) rd_pulses <= rd_pulses + 1;
        if (done0)  done_pulses <= done_pulses + 1;
    end

    // Frame monitor: captures each frame cycle by cycle, compares it against the scoreboard
    // head and expects done_o in the cycle after the last stop-bit cycle.
    initial begin : monitor
        logic [63:0]  got_w;
        logic [W-1:0] d;
        bit           aborted;
        forever begin
            @(negedge clk);
            if (rst_n && tx0 === 1'b0) begin
                mon_starts.push_back(cyc);
                got_w    = '0;
                got_w[0] = tx0;
                aborted  = 1'b0;
                for (int i = 1; i < F0; i++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    got_w[i] = tx0;
                end
                if (sb.size() == 0) begin
                    check_eq("unexpected_frame", sb.size(), 1);
                end else begin
                    d = sb.pop_front();
                    // a frame cut by reset carries a word that is dropped, never resent
                    if (!aborted) begin
                        check_eq("frame", got_w, exp_wave(d, 1'b0, 1'b0));
                        @(negedge clk);
                        check_eq("done_after_stop", done0, 1'b1);
                    end
                end
            end
        end
    end

    task automatic push(input logic [W-1:0] d);
        mem[wr_cnt[7:0]] = d;
        wr_cnt = wr_cnt + 1;
        sb.push_back(d);
    endtask

    task automatic wait_start(input string tag, input int n, input int budget, output int ts);
        int k = 0;
        while (mon_starts.size() <= n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, (mon_starts.size() > n), 1'b1);
        ts = (mon_starts.size() > n) ? mon_starts[n] : cyc;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k = 0;
        while (!(sb.size() == 0 && busy0 === 1'b0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, (k < budget), 1'b1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int           t0, ts, n, bad, k;
        logic [63:0]  got_o, got_e;
        logic [W-1:0] pd;

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx0, 1'b1);
        check_eq("rst_rd_en", rd_en0, 1'b0);
        check_eq("rst_busy", busy0, 1'b0);
        check_eq("rst_done", done0, 1'b0);
        check_eq("rst_tx_par", {tx_po, tx_pe}, 2'b11);
        rst_n = 1'b1;

        // idle with empty fifo and enable high
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || rd_en0 !== 1'b0 || busy0 !== 1'b0) bad++;
        end
        check_eq("idle_100_bad_cycles", bad, 0);

        // single frame 0xA5
        @(negedge clk);
        push(8'hA5);
        t0 = cyc;
        n  = mon_starts.size();
        wait_start("a5_start_seen", n, 20, ts);
        check_eq("a5_start_latency", ts - t0, 3);
        wait_drain("a5_drain", 200);
        check_eq("a5_rd_pulses", rd_pulses, 1);
        check_eq("a5_done_pulses", done_pulses, 1);

        // back-to-back 0x00, 0xFF, 0x3C
        n = mon_starts.size();
        @(negedge clk); push(8'h00);
        @(negedge clk); push(8'hFF);
        @(negedge clk); push(8'h3C);
        wait_drain("b2b_drain", 400);
        check_eq("b2b_frames", mon_starts.size(), n + 3);
        if (mon_starts.size() >= n + 3) begin
            check_eq("b2b_gap1", mon_starts[n+1] - mon_starts[n] - F0, 3);
            check_eq("b2b_gap2", mon_starts[n+2] - mon_starts[n+1] - F0, 3);
        end
        check_eq("b2b_fifo_empty", (wr_cnt == rd_cnt), 1'b1);
        check_eq("b2b_fifo_err", ferr, 1'b0);

        // parity frames for 0x07 (three ones): odd parity bit 0, even parity bit 1
        pd = 8'h07;
        @(negedge clk);
        pw    = pd;
        pw_wr = pw_wr + 1;
        t0    = cyc;
        k     = 0;
        while (tx_po !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("par_start_latency", cyc - t0, 3);
        got_o = '0;
        got_e = '0;
        for (int i = 0; i < FP; i++) begin
            if (i != 0) @(negedge clk);
            got_o[i] = tx_po;
            got_e[i] = tx_pe;
        end
        check_eq("par_odd_frame", got_o, exp_wave(pd, 1'b1, ~(^pd)));
        check_eq("par_even_frame", got_e, exp_wave(pd, 1'b1, ^pd));
        check_eq("par_odd_bit", got_o[(W+1)*CPB], 1'b0);
        check_eq("par_even_bit", got_e[(W+1)*CPB], 1'b1);
        @(negedge clk);
        check_eq("par_done_44", {done_po, done_pe}, 2'b11);
        check_eq("par_single_pop", {po_rd[7:0], pe_rd[7:0]}, 16'h0101);

        // reset in the middle of data bit 3, second word waiting behind it
        n = mon_starts.size();
        @(negedge clk); push(8'h5A);
        @(negedge clk); push(8'hC3);
        wait_start("rst_frame_start", n, 20, ts);
        while (cyc < ts + CPB + 3*CPB + 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_tx_high", tx0, 1'b1);
        check_eq("midrst_busy_low", busy0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_drain("after_rst_drain", 200);
        check_eq("after_rst_frames", mon_starts.size(), n + 2);
        check_eq("after_rst_fifo_empty", (wr_cnt == rd_cnt), 1'b1);

        // enable dropped mid-frame with two words queued
        n = mon_starts.size();
        @(negedge clk); push(8'h96);
        @(negedge clk); push(8'h69);
        wait_start("en_frame_start", n, 20, ts);
        while (cyc < ts + 10) @(negedge clk);
        en0 = 1'b0;
        while (cyc < ts + F0 + 60) @(negedge clk);
        check_eq("en_low_frames", mon_starts.size(), n + 1);
        check_eq("en_low_busy", busy0, 1'b0);
        check_eq("en_low_left_in_fifo", wr_cnt - rd_cnt, 1);
        check_eq("en_low_sb_left", sb.size(), 1);
        en0 = 1'b1;
        wait_drain("en_high_drain", 200);
        check_eq("en_high_frames", mon_starts.size(), n + 2);

        check_eq("total_rd_pulses", rd_pulses, 8);
        check_eq("total_done_pulses", done_pulses, 7);
        check_eq("final_fifo_err", ferr, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
